mioc_dram_ctl: RTL and testbench

Clocked DRAM timing sequencer and bus arbiter for the MIOC. It generates RAS_N, MUX, CAS1_N and CAS2_N for three kinds of requester: Z80 memory cycles, Z80 refresh cycles, and 6801 DMA transfers. It also runs the BUSRQ_N/BUSAK_N handshake that takes the Z80 off the bus for DMA. It sits between the buffered Z80 control pins and the DRAM array, and replaces the asynchronous strobe gating.

---
 rtl/mioc_dram_ctl.sv | 179 +++++++++++++++++
 tb/tb_mioc_dram_ctl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mioc_dram_ctl.sv
// DRAM strobe sequencer and Z80/6801 bus arbiter for the MIOC.
// A request is accepted on one edge and its strobes begin on the following edge.
module mioc_dram_ctl #(
    parameter int unsigned CAS_DMA = 2,
    parameter int unsigned PRE_CYC = 1
) (
    input  logic B_PHI,
    input  logic RST,
    input  logic BMREQ_N,
    input  logic BRFSH_N,
    input  logic BA15,
    input  logic RAMSEL,
    input  logic DMA_N,
    input  logic DMA_CYC_N,
    input  logic DMA_A15,
    input  logic BUSAK_N,
    output logic BUSRQ_N,
    output logic ADDRBUFEN_N,
    output logic DMA_GNT,
    output logic DMA_ACK,
    output logic RAS_N,
    output logic MUX,
    output logic CAS1_N,
    output logic CAS2_N
);
    typedef enum logic [2:0] {
        StIdle, StRow, StCol, StCas, StPre, StRef
    } dram_state_e;

    typedef enum logic [1:0] {
        BusZ80, BusReq, BusDma, BusRel
    } bus_state_e;

    localparam logic [2:0] CasLast = 3'(CAS_DMA);
    localparam logic [2:0] PreLast = 3'(PRE_CYC);
    localparam logic [2:0] RefMin  = 3'd2;

    dram_state_e dram_q, dram_d;
    bus_state_e  bus_q, bus_d;
    logic        go_q, go_d;     // request accepted, strobes start next edge
    logic        ref_q, ref_d;
    logic        dma_q, dma_d;
    logic        bank_q, bank_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        dram_idle, z80_abort, granted;

    assign dram_idle = (dram_q == StIdle) && !go_q;
    assign z80_abort = !dma_q && BMREQ_N;
    assign granted   = (bus_q == BusDma);

    always_comb begin : bus_next
        bus_d = bus_q;
        case (bus_q)
            BusZ80: if (!DMA_N) bus_d = BusReq;
            BusReq: begin
                if (DMA_N) begin
                    bus_d = BusZ80;
                end else if (!BUSAK_N) begin
                    bus_d = BusDma;
                end
            end
            BusDma: if (DMA_N && dram_idle) bus_d = BusRel;
            BusRel: bus_d = BusZ80;
            default: bus_d = BusZ80;
        endcase
    end

    always_comb begin : dram_next
        dram_d = dram_q;
        go_d   = 1'b0;
        ref_d  = ref_q;
        dma_d  = dma_q;
        bank_d = bank_q;
        cnt_d  = cnt_q;
        case (dram_q)
            StIdle: begin
                if (go_q) begin
                    dram_d = ref_q ? StRef : StRow;
                    cnt_d  = 3'd1;
                end else if (!BMREQ_N && !BRFSH_N) begin
                    go_d  = 1'b1;
                    ref_d = 1'b1;
                    dma_d = 1'b0;
                end else if (!BMREQ_N && RAMSEL && !granted) begin
                    go_d   = 1'b1;
                    ref_d  = 1'b0;
                    dma_d  = 1'b0;
                    bank_d = BA15;
                end else if (granted && (bus_d == BusDma) && !DMA_CYC_N) begin
                    // No new DMA access on the edge the bus is being handed back.
                    go_d   = 1'b1;
                    ref_d  = 1'b0;
                    dma_d  = 1'b1;
                    bank_d = DMA_A15;
                end
            end
            StRow: begin
                if (z80_abort) begin
                    dram_d = StPre;
                    cnt_d  = 3'd1;
                end else begin
                    dram_d = StCol;
                end
            end
            StCol: begin
                dram_d = z80_abort ? StPre : StCas;
                cnt_d  = 3'd1;
            end
            StCas: begin
                if (dma_q) begin
                    if (cnt_q == CasLast) begin
                        dram_d = StPre;
                        cnt_d  = 3'd1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (BMREQ_N) begin
                    dram_d = StPre;
                    cnt_d  = 3'd1;
                end
            end
            StRef: begin
                if (cnt_q >= RefMin) begin
                    if (BMREQ_N) begin
                        dram_d = StPre;
                        cnt_d  = 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StPre: begin
                if (cnt_q == PreLast) begin
                    dram_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: dram_d = StIdle;
        endcase
    end

    always_ff @(posedge B_PHI) begin
        if (RST) begin
            dram_q      <= StIdle;
            bus_q       <= BusZ80;
            go_q        <= 1'b0;
            ref_q       <= 1'b0;
            dma_q       <= 1'b0;
            bank_q      <= 1'b0;
            cnt_q       <= 3'd0;
            BUSRQ_N     <= 1'b1;
            ADDRBUFEN_N <= 1'b0;
            DMA_GNT     <= 1'b0;
            DMA_ACK     <= 1'b0;
            RAS_N       <= 1'b1;
            MUX         <= 1'b0;
            CAS1_N      <= 1'b1;
            CAS2_N      <= 1'b1;
        end else begin
            dram_q      <= dram_d;
            bus_q       <= bus_d;
            go_q        <= go_d;
            ref_q       <= ref_d;
            dma_q       <= dma_d;
            bank_q      <= bank_d;
            cnt_q       <= cnt_d;
            BUSRQ_N     <= !((bus_d == BusReq) || (bus_d == BusDma));
            ADDRBUFEN_N <= (bus_d == BusDma) || (bus_d == BusRel);
            DMA_GNT     <= (bus_d == BusDma);
            DMA_ACK     <= (dram_d == StCas) && dma_d && (cnt_d == CasLast);
            RAS_N       <= !((dram_d == StRow) || (dram_d == StCol) ||
                             (dram_d == StCas) || (dram_d == StRef));
            MUX         <= (dram_d == StCol) || (dram_d == StCas);
            CAS1_N      <= !((dram_d == StCas) && !bank_d);
            CAS2_N      <= !((dram_d == StCas) && bank_d);
        end
    end
endmodule

// File: tb/tb_mioc_dram_ctl.sv
// Bench for mioc_dram_ctl: directed and randomized transactions checked edge by edge
// against timelines computed from the access rules.
module tb_mioc_dram_ctl;
    localparam int CAS_DMA = 2;
    localparam int PRE_CYC = 1;
    localparam logic [7:0] IDLE_V = 8'b100_01011;

    logic B_PHI, RST, BMREQ_N, BRFSH_N, BA15, RAMSEL, DMA_N, DMA_CYC_N, DMA_A15, BUSAK_N;
    logic BUSRQ_N, ADDRBUFEN_N, DMA_GNT, DMA_ACK, RAS_N, MUX, CAS1_N, CAS2_N;

    int checks = 0;
    int errors = 0;

    mioc_dram_ctl #(
        .CAS_DMA(CAS_DMA),
        .PRE_CYC(PRE_CYC)
    ) dut (
        .B_PHI      (B_PHI),
        .RST        (RST),
        .BMREQ_N    (BMREQ_N),
        .BRFSH_N    (BRFSH_N),
        .BA15       (BA15),
        .RAMSEL     (RAMSEL),
        .DMA_N      (DMA_N),
        .DMA_CYC_N  (DMA_CYC_N),
        .DMA_A15    (DMA_A15),
        .BUSAK_N    (BUSAK_N),
        .BUSRQ_N    (BUSRQ_N),
        .ADDRBUFEN_N(ADDRBUFEN_N),
        .DMA_GNT    (DMA_GNT),
        .DMA_ACK    (DMA_ACK),
        .RAS_N      (RAS_N),
        .MUX        (MUX),
        .CAS1_N     (CAS1_N),
        .CAS2_N     (CAS2_N)
    );

    initial B_PHI = 1'b0;
    always #5 B_PHI = ~B_PHI;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge B_PHI);
        #1;
    endtask

    // {BUSRQ_N, ADDRBUFEN_N, DMA_GNT, DMA_ACK, RAS_N, MUX, CAS1_N, CAS2_N}
    task automatic check(input string tag, input int n, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {BUSRQ_N, ADDRBUFEN_N, DMA_GNT, DMA_ACK, RAS_N, MUX, CAS1_N, CAS2_N};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    // Edge n of an access accepted at edge 0 and released at edge r:
    // RAS low on edges 1..r-1, MUX high 2..r-1, CAS low 3..r-1, ACK on r-1 for DMA.
    function automatic logic [4:0] dram_exp(input int n, input int r, input logic bank,
                                            input logic active, input logic ras_only,
                                            input logic dma);
        logic ras, mux, cas;
        ras = active && (n >= 1) && (n <= r - 1);
        mux = active && !ras_only && (n >= 2) && (n <= r - 1);
        cas = mux && (n >= 3);
        return {dma && active && (n == r - 1), !ras, mux, !(cas && !bank), !(cas && bank)};
    endfunction

    task automatic z80_txn(input string tag, input int len, input logic bank,
                           input logic ramsel, input logic refresh, input int extra);
        int r;
        if (refresh) r = (len > 3) ? len : 3;
        else         r = (len > 2) ? len : 2;
        BMREQ_N = 1'b0;
        BRFSH_N = !refresh;
        BA15    = bank;
        RAMSEL  = ramsel;
        for (int n = 0; n < r + PRE_CYC + 1 + extra; n++) begin
            tick();
            check(tag, n, {3'b100, dram_exp(n, r, bank, refresh || ramsel, refresh, 1'b0)});
            if (n + 1 >= len) begin
                BMREQ_N = 1'b1;
                BRFSH_N = 1'b1;
            end
        end
    endtask

    task automatic grant(input string tag, input int wait_cyc);
        DMA_N = 1'b0;
        for (int n = 0; n < wait_cyc; n++) begin
            tick();
            check(tag, n, 8'b000_01011);
        end
        BUSAK_N = 1'b0;
        tick();
        check(tag, wait_cyc, 8'b011_01011);
    endtask

    task automatic release_bus(input string tag);
        DMA_N = 1'b1;
        tick();
        check(tag, 0, 8'b110_01011);
        BUSAK_N = 1'b1;
        tick();
        check(tag, 1, IDLE_V);
    endtask

    task automatic dma_txn(input string tag, input logic bank, input bit drop, input int extra);
        int r, rel, total;
        logic [2:0] bus_v;
        r     = 3 + CAS_DMA;
        rel   = drop ? r + PRE_CYC + 1 : 1 << 20;
        total = drop ? rel + 2 : r + PRE_CYC + 1 + extra;
        DMA_CYC_N = 1'b0;
        DMA_A15   = bank;
        for (int n = 0; n < total; n++) begin
            tick();
            if (n < rel)       bus_v = 3'b011;
            else if (n == rel) bus_v = 3'b110;
            else               bus_v = 3'b100;
            check(tag, n, {bus_v, dram_exp(n, r, bank, 1'b1, 1'b0, 1'b1)});
            if (n + 1 >= r) DMA_CYC_N = 1'b1;
            if (drop && n == 1) DMA_N = 1'b1;
            if (n == rel) BUSAK_N = 1'b1;
        end
    endtask

    initial begin
        RST = 1'b1; BMREQ_N = 1'b1; BRFSH_N = 1'b1; BA15 = 1'b0; RAMSEL = 1'b0;
        DMA_N = 1'b1; DMA_CYC_N = 1'b1; DMA_A15 = 1'b0; BUSAK_N = 1'b1;
        tick();
        tick();
        check("reset", 0, IDLE_V);
        RST = 1'b0;
        tick();
        check("post_reset", 0, IDLE_V);

        z80_txn("z80_bank1", 5, 1'b1, 1'b1, 1'b0, 1);
        z80_txn("z80_bank0", 4, 1'b0, 1'b1, 1'b0, 0);
        z80_txn("refresh", 1, 1'b0, 1'b0, 1'b1, 1);
        z80_txn("no_ramsel", 5, 1'b1, 1'b0, 1'b0, 1);
        z80_txn("abort_row", 2, 1'b1, 1'b1, 1'b0, 0);
        z80_txn("abort_col", 3, 1'b0, 1'b1, 1'b0, 0);

        // Reset while a Z80 access holds CAS.
        BMREQ_N = 1'b0; RAMSEL = 1'b1; BA15 = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        check("pre_rst_cas", 3, {3'b100, dram_exp(3, 99, 1'b0, 1'b1, 1'b0, 1'b0)});
        RST = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("mid_rst", n, IDLE_V);
        end
        RST = 1'b0; BMREQ_N = 1'b1;
        tick();
        check("rst_exit", 0, IDLE_V);

        DMA_N = 1'b0;
        tick();
        check("req_abort", 0, 8'b000_01011);
        DMA_N = 1'b1;
        tick();
        check("req_abort", 1, IDLE_V);

        grant("grant", 4);
        dma_txn("dma_b0", 1'b0, 1'b0, 0);
        dma_txn("dma_b1", 1'b1, 1'b0, 0);
        release_bus("release");

        grant("grant2", 2);
        dma_txn("dma_drop", 1'b1, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            int unsigned op;
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                z80_txn($sformatf("rnd%0d_z80", i), int'($urandom_range(1, 8)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0,
                        int'($urandom_range(0, 2)));
            end else if (op == 2) begin
                z80_txn($sformatf("rnd%0d_ref", i), int'($urandom_range(1, 5)), 1'b0,
                        1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 2)));
            end else begin
                int k;
                bit drop;
                k = int'($urandom_range(1, 3));
                drop = ($urandom_range(0, 1) == 1);
                grant($sformatf("rnd%0d_gnt", i), int'($urandom_range(1, 5)));
                for (int j = 0; j < k; j++) begin
                    dma_txn($sformatf("rnd%0d_dma%0d", i, j), 1'($urandom_range(0, 1)),
                            drop && (j == k - 1), int'($urandom_range(0, 2)));
                end
                if (!drop) release_bus($sformatf("rnd%0d_rel", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
